// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: FSM state encoding, coin values
// and the change-amount width shared with the cola controller's out_m.
package change_dispenser_pkg;

  localparam int CD_W_M = 5;
  localparam int CNT_W  = 8;

  // Coin values in half-units
  localparam int ONE  = 2;
  localparam int HALF = 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    DONE     = 2'd3
  } cd_state_e;

  typedef enum logic {
    SEL_ONE  = 1'b0,
    SEL_HALF = 1'b1
  } coin_sel_e;

endpackage

// File: rtl/change_dispenser_coin_hopper_cnt.sv
// Loadable saturating down-counter tracking the coins left in one hopper tube.
module coin_hopper_cnt #(
  parameter int             W    = 8,
  parameter logic [W-1:0]   INIT = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= INIT;
    end else if (load) begin
      count <= INIT;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount as single coin-eject pulses with per-coin hopper ack.
// Optional JAM_TIMEOUT_EN adds an ack timeout that raises a sticky jam fault.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int W_M    = CD_W_M,
  parameter int N_ONE  = 15,
  parameter int N_HALF = 15,
  parameter int ACK_TO = 50
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           chg_valid,
  input  logic [W_M-1:0] chg_m,
  output logic           chg_ready,
  input  logic           coin_ack,
  input  logic           refill,
  output logic           coin_one,
  output logic           coin_half,
  output logic           busy,
  output logic           done,
  output logic           short,
  output logic [W_M-1:0] owed,
  output logic           jam
);

  // state    | meaning
  // IDLE     | ready for a request; refill honoured here only
  // ISSUE    | pick next coin (1.0 first, then 0.5) or finish
  // WAIT_ACK | eject pulse in first cycle, wait for hopper ack
  // DONE     | one-cycle done pulse with short/owed

  cd_state_e        state, state_nx;
  coin_sel_e        sel, sel_nx;
  logic [W_M-1:0]   rem, rem_nx;
  logic [W_M-1:0]   owed_nx;
  logic             short_nx, done_nx, busy_nx, ready_nx;
  logic             coin_one_nx, coin_half_nx;
  logic             one_dec, half_dec, reload;
  logic             jam_nx;
  logic [CNT_W-1:0] one_cnt, half_cnt;

  coin_hopper_cnt #(.W(CNT_W), .INIT(CNT_W'(N_ONE))) u_one_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (reload),
    .dec   (one_dec),
    .count (one_cnt)
  );

  coin_hopper_cnt #(.W(CNT_W), .INIT(CNT_W'(N_HALF))) u_half_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (reload),
    .dec   (half_dec),
    .count (half_cnt)
  );

`ifdef JAM_TIMEOUT_EN
  localparam int TMR_W = $clog2(ACK_TO + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ACK_TO - 1);

  logic             jam_q;
  logic [TMR_W-1:0] tmr, tmr_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jam_q <= 1'b0;
      tmr   <= '0;
    end else begin
      jam_q <= jam_nx;
      tmr   <= tmr_nx;
    end
  end

  assign jam = jam_q;
`else
  assign jam = 1'b0;
`endif

  always_comb begin
    state_nx     = state;
    sel_nx       = sel;
    rem_nx       = rem;
    short_nx     = short;
    owed_nx      = owed;
    done_nx      = 1'b0;
    coin_one_nx  = 1'b0;
    coin_half_nx = 1'b0;
    one_dec      = 1'b0;
    half_dec     = 1'b0;
    reload       = 1'b0;
`ifdef JAM_TIMEOUT_EN
    jam_nx       = jam_q;
    tmr_nx       = tmr;
`else
    jam_nx       = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (refill) begin
          reload = 1'b1;
          jam_nx = 1'b0;
        end
        if (chg_valid && chg_ready) begin
          rem_nx   = chg_m;
          short_nx = 1'b0;
          owed_nx  = '0;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if ((rem >= W_M'(ONE)) && (one_cnt != '0)) begin
          coin_one_nx = 1'b1;
          sel_nx      = SEL_ONE;
          state_nx    = WAIT_ACK;
`ifdef JAM_TIMEOUT_EN
          tmr_nx      = TMR_LOAD;
`endif
        end else if ((rem != '0) && (half_cnt != '0)) begin
          coin_half_nx = 1'b1;
          sel_nx       = SEL_HALF;
          state_nx     = WAIT_ACK;
`ifdef JAM_TIMEOUT_EN
          tmr_nx       = TMR_LOAD;
`endif
        end else begin
          // rem is either paid off or unpayable with what is left
          done_nx  = 1'b1;
          short_nx = (rem != '0);
          owed_nx  = rem;
          state_nx = DONE;
        end
      end
      WAIT_ACK: begin
        if (coin_ack) begin
          if (sel == SEL_ONE) begin
            rem_nx  = rem - W_M'(ONE);
            one_dec = 1'b1;
          end else begin
            rem_nx   = rem - W_M'(HALF);
            half_dec = 1'b1;
          end
          state_nx = ISSUE;
        end
`ifdef JAM_TIMEOUT_EN
        else if (tmr == '0) begin
          // the ejected coin is treated as not dispensed
          done_nx  = 1'b1;
          short_nx = 1'b1;
          owed_nx  = rem;
          jam_nx   = 1'b1;
          state_nx = DONE;
        end else begin
          tmr_nx = tmr - 1'b1;
        end
`endif
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    busy_nx  = (state_nx == ISSUE) || (state_nx == WAIT_ACK);
    ready_nx = (state_nx == IDLE) && !jam_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= SEL_ONE;
      rem       <= '0;
      chg_ready <= 1'b1;
      coin_one  <= 1'b0;
      coin_half <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      short     <= 1'b0;
      owed      <= '0;
    end else begin
      state     <= state_nx;
      sel       <= sel_nx;
      rem       <= rem_nx;
      chg_ready <= ready_nx;
      coin_one  <= coin_one_nx;
      coin_half <= coin_half_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      short     <= short_nx;
      owed      <= owed_nx;
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser (default parameters);
// inventory depletion cases are reached by draining the hoppers.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       chg_valid = 1'b0;
  logic [4:0] chg_m = '0;
  logic       chg_ready;
  logic       coin_ack = 1'b0;
  logic       refill = 1'b0;
  logic       coin_one, coin_half, busy, done, short, jam;
  logic [4:0] owed;

  int n_chk  = 0;
  int n_fail = 0;

  change_dispenser dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .chg_valid (chg_valid),
    .chg_m     (chg_m),
    .chg_ready (chg_ready),
    .coin_ack  (coin_ack),
    .refill    (refill),
    .coin_one  (coin_one),
    .coin_half (coin_half),
    .busy      (busy),
    .done      (done),
    .short     (short),
    .owed      (owed),
    .jam       (jam)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_refill();
    @(negedge clk);
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
  endtask

  // Handshake a request; returns in the ISSUE cycle.
  task automatic start(input logic [4:0] m, input bit hold);
    @(negedge clk);
    chk("ready_before_req", chg_ready, 1);
    chg_valid = 1'b1;
    chg_m     = m;
    @(negedge clk);
    if (!hold) chg_valid = 1'b0;
    chk("busy_in_issue", busy, 1);
    chk("ready_in_issue", chg_ready, 0);
  endtask

  // Ack each coin ack_dly cycles after its pulse (negative: never ack).
  // cyc counts cycles from the handshake cycle to the done cycle.
  task automatic run(input int ack_dly, input int budget,
                     output int n1, output int nh, output bit got,
                     output int cyc, output bit sh, output int ow);
    int k;
    k = -1; n1 = 0; nh = 0; got = 0; cyc = -1; sh = 0; ow = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      coin_ack = 1'b0;
      if (done) begin
        got = 1; cyc = c + 2; sh = short; ow = int'(owed);
        break;
      end
      if (coin_one)  n1++;
      if (coin_half) nh++;
      if ((coin_one || coin_half) && ack_dly >= 0) k = ack_dly;
      if (k == 0) begin
        coin_ack = 1'b1;
        k = -1;
      end else if (k > 0) begin
        k--;
      end
    end
  endtask

  int n1, nh, cyc, ow;
  bit got, sh;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", chg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_coin", {coin_one, coin_half}, 0);
    chk("rst_short_owed", {short, owed}, 0);
    chk("rst_jam", jam, 0);
    chk("rst_one_cnt", dut.one_cnt, 15);
    chk("rst_half_cnt", dut.half_cnt, 15);
    rst_n = 1'b1;

    // 7 half-units: 3 x 1.0 + 1 x 0.5, ack 3 cycles after each pulse
    start(5'd7, 0);
    run(3, 200, n1, nh, got, cyc, sh, ow);
    chk("t1_done", got, 1);
    chk("t1_n_one", n1, 3);
    chk("t1_n_half", nh, 1);
    chk("t1_short", sh, 0);
    chk("t1_owed", ow, 0);
    chk("t1_one_cnt", dut.one_cnt, 12);
    chk("t1_half_cnt", dut.half_cnt, 14);

    // zero request: done 2 cycles after the handshake
    start(5'd0, 0);
    run(3, 20, n1, nh, got, cyc, sh, ow);
    chk("t2_done", got, 1);
    chk("t2_latency", cyc, 2);
    chk("t2_coins", n1 + nh, 0);
    chk("t2_short", sh, 0);

    // drain 1.0 tube down to one coin, then 6 -> 1 x 1.0 + 4 x 0.5
    do_refill();
    chk("refill_one_cnt", dut.one_cnt, 15);
    start(5'd28, 0);
    run(0, 200, n1, nh, got, cyc, sh, ow);
    chk("drain_n_one", n1, 14);
    chk("drain_one_cnt", dut.one_cnt, 1);
    start(5'd6, 0);
    run(1, 200, n1, nh, got, cyc, sh, ow);
    chk("t3_done", got, 1);
    chk("t3_n_one", n1, 1);
    chk("t3_n_half", nh, 4);
    chk("t3_short", sh, 0);
    chk("t3_half_cnt", dut.half_cnt, 11);

    // inventory 0 x 1.0 / 2 x 0.5, request 5 -> short by 3
    do_refill();
    start(5'd30, 0);
    run(0, 200, n1, nh, got, cyc, sh, ow);
    chk("drain2_n_one", n1, 15);
    start(5'd13, 0);
    run(0, 200, n1, nh, got, cyc, sh, ow);
    chk("drain2_n_half", nh, 13);
    chk("drain2_half_cnt", dut.half_cnt, 2);
    start(5'd5, 0);
    run(2, 200, n1, nh, got, cyc, sh, ow);
    chk("t4_done", got, 1);
    chk("t4_n_one", n1, 0);
    chk("t4_n_half", nh, 2);
    chk("t4_short", sh, 1);
    chk("t4_owed", ow, 3);
    @(negedge clk);
    chk("t4_short_hold", short, 1);
    chk("t4_owed_hold", owed, 3);
    start(5'd1, 0);
    run(0, 50, n1, nh, got, cyc, sh, ow);
    chk("empty_coins", n1 + nh, 0);
    chk("empty_owed", ow, 1);
    chk("empty_one_cnt", dut.one_cnt, 0);
    chk("empty_half_cnt", dut.half_cnt, 0);
    do_refill();
    start(5'd2, 0);
    run(0, 50, n1, nh, got, cyc, sh, ow);
    chk("t4b_n_one", n1, 1);
    chk("t4b_n_half", nh, 0);
    chk("t4b_short", sh, 0);
    chk("t4b_owed", ow, 0);

    // reset while waiting for ack
    start(5'd4, 0);
    repeat (3) @(negedge clk);
    chk("t5_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_ready", chg_ready, 1);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_coin", {coin_one, coin_half}, 0);
    chk("t5_one_cnt", dut.one_cnt, 15);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_no_done", done, 0);
    chk("t5_idle_ready", chg_ready, 1);

    // chg_valid held high throughout: only one request taken
    start(5'd2, 1);
    run(1, 50, n1, nh, got, cyc, sh, ow);
    chk("t5b_done", got, 1);
    chk("t5b_n_one", n1, 1);
    @(negedge clk);
    chg_valid = 1'b0;
    @(negedge clk);
    chk("t5b_no_reaccept", busy, 0);
    chk("t5b_ready", chg_ready, 1);

    // ack withheld
    start(5'd4, 0);
    run(-1, 80, n1, nh, got, cyc, sh, ow);
`ifdef JAM_TIMEOUT_EN
    chk("t6_done", got, 1);
    chk("t6_latency", cyc, 52);
    chk("t6_n_one", n1, 1);
    chk("t6_short", sh, 1);
    chk("t6_owed", ow, 4);
    @(negedge clk);
    chk("t6_jam", jam, 1);
    chk("t6_ready", chg_ready, 0);
    chk("t6_one_cnt", dut.one_cnt, 14);
    do_refill();
    chk("t6_jam_clr", jam, 0);
    chk("t6_ready_clr", chg_ready, 1);
`else
    chk("t6_no_done", got, 0);
    chk("t6_n_one", n1, 1);
    chk("t6_busy", busy, 1);
    chk("t6_jam", jam, 0);
    coin_ack = 1'b1;
    run(0, 50, n1, nh, got, cyc, sh, ow);
    chk("t6_late_done", got, 1);
    chk("t6_late_n_one", n1, 1);
    chk("t6_late_short", sh, 0);
    chk("t6_one_cnt", dut.one_cnt, 12);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
